// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite definitions used across the interconnect.
package ahb3lite_pkg;

  // HTRANS encodings.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage : ahb3lite_pkg

// File: rtl/ahb3lite_interconnect_slave_priority.sv
// Finds the highest priority level requested by any master in the index
// range LO..HI that is currently selecting this slave. Returns 0 when no
// master in the range is requesting.
module ahb3lite_interconnect_slave_priority #(
  parameter int MASTERS       = 3,
  parameter int HI            = MASTERS - 1,
  parameter int LO            = 0,
  parameter int PRIORITY_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0]       HSEL,
  input  logic [PRIORITY_BITS-1:0] priority_i [MASTERS],
  output logic [PRIORITY_BITS-1:0] priority_o
);

  // Linear max over the requesting masters; ties need no resolution here,
  // the arbiter picks among equals.
  always_comb begin
    priority_o = '0;
    for (int i = LO; i <= HI; i++) begin
      if (HSEL[i] && (priority_i[i] > priority_o)) begin
        priority_o = priority_i[i];
      end
    end
  end

endmodule : ahb3lite_interconnect_slave_priority

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave-port arbiter. Picks one master among those requesting at the
// highest priority level, rotating fairly among equals, holds the grant for
// bursts and locked sequences, and tracks which master owns the data phase.
//
// Handshake: HREADY is the slave's acceptance strobe. An address phase is
// accepted only on a rising edge with HREADY=1; with HREADY=0 every piece of
// state (grant, round-robin pointer, data phase) is frozen. The grant outputs
// name the address-phase owner; data_valid/data_idx name the master whose
// transfer was accepted on the previous HREADY=1 edge.
module ahb3lite_interconnect_slave_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int MASTERS       = 3,
  parameter int MASTER_BITS   = (MASTERS == 1) ? 1 : $clog2(MASTERS),
  parameter int PRIORITY_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [MASTERS-1:0]       HSEL,
  input  logic [PRIORITY_BITS-1:0] priority_i [MASTERS],
  input  logic [1:0]               HTRANS     [MASTERS],
  input  logic [MASTERS-1:0]       HMASTLOCK,
  input  logic                     HREADY,
  output logic                     grant_valid,
  output logic [MASTERS-1:0]       grant_onehot,
  output logic [MASTER_BITS-1:0]   grant_idx,
  output logic                     data_valid,
  output logic [MASTER_BITS-1:0]   data_idx
);

  // Pointer starts at the last master so master 0 is first among equals.
  localparam logic [MASTER_BITS-1:0] LAST_IDX_RESET = MASTER_BITS'(MASTERS - 1);

  logic [PRIORITY_BITS-1:0] top_prio;
  logic [MASTERS-1:0]       cand;
  logic [MASTER_BITS-1:0]   last_idx;
  logic                     owner_sel;
  logic                     owner_lock;
  logic [1:0]               owner_trans;
  logic                     hold;
  logic                     win_found;
  logic [MASTER_BITS-1:0]   win_idx;
  logic [MASTER_BITS:0]     rr_result;

  // Round-robin search: the first requesting index after 'last', wrapping at
  // MASTERS (not at 2**MASTER_BITS). Scanning from the farthest position to
  // the nearest lets the nearest match overwrite the result. Returns
  // {found, index}.
  function automatic logic [MASTER_BITS:0] rr_pick(
    input logic [MASTERS-1:0]     req,
    input logic [MASTER_BITS-1:0] last
  );
    logic [MASTER_BITS:0] result;
    int                   idx;
    result = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= MASTERS) begin
        idx = idx - MASTERS;
      end
      if (req[idx]) begin
        result = {1'b1, MASTER_BITS'(idx)};
      end
    end
    return result;
  endfunction

  ahb3lite_interconnect_slave_priority #(
    .MASTERS       (MASTERS),
    .HI            (MASTERS - 1),
    .LO            (0),
    .PRIORITY_BITS (PRIORITY_BITS)
  ) u_priority (
    .HSEL       (HSEL),
    .priority_i (priority_i),
    .priority_o (top_prio)
  );

  // Candidates are the requesting masters at the winning priority level.
  always_comb begin
    cand = '0;
    for (int i = 0; i < MASTERS; i++) begin
      cand[i] = HSEL[i] && (priority_i[i] == top_prio);
    end
  end

  // Gather the current owner's request, lock and transfer type. A compare
  // loop keeps the index inside 0..MASTERS-1 for any MASTERS value.
  always_comb begin
    owner_sel   = 1'b0;
    owner_lock  = 1'b0;
    owner_trans = HTRANS_IDLE;
    for (int i = 0; i < MASTERS; i++) begin
      if (grant_idx == MASTER_BITS'(i)) begin
        owner_sel   = HSEL[i];
        owner_lock  = HMASTLOCK[i];
        owner_trans = HTRANS[i];
      end
    end
  end

  // The owner keeps the grant through a locked sequence or while it is in
  // the middle of a burst (BUSY/SEQ); dropping HSEL always releases it.
  always_comb begin
    hold = grant_valid && owner_sel &&
           (owner_lock || (owner_trans == HTRANS_BUSY) || (owner_trans == HTRANS_SEQ));
  end

  // Winner of this cycle's arbitration, using this cycle's inputs so a
  // release and a new request in the same cycle leave no idle bubble.
  always_comb begin
    rr_result = rr_pick(cand, last_idx);
    win_found = rr_result[MASTER_BITS];
    win_idx   = rr_result[MASTER_BITS-1:0];
  end

  // Grant, round-robin pointer and data-phase registers; everything advances
  // only on an accepted address phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last_idx    <= LAST_IDX_RESET;
      data_valid  <= 1'b0;
      data_idx    <= '0;
    end else if (HREADY) begin
      data_valid <= grant_valid && owner_sel && owner_trans[1];
      data_idx   <= grant_idx;
      if (!hold) begin
        if (win_found) begin
          grant_valid <= 1'b1;
          grant_idx   <= win_idx;
          last_idx    <= win_idx;
        end else begin
          grant_valid <= 1'b0;
        end
      end
    end
  end

  // One-hot view derived from the binary owner so the two can never disagree.
  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < MASTERS; i++) begin
      grant_onehot[i] = grant_valid && (grant_idx == MASTER_BITS'(i));
    end
  end

endmodule : ahb3lite_interconnect_slave_arbiter

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// Testbench for ahb3lite_interconnect_slave_arbiter with three masters.
module tb_ahb3lite_interconnect_slave_arbiter;

  localparam int M  = 3;
  localparam int MB = 2;
  localparam int PB = 2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  // ---------------- clock / reset / DUT ----------------
  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [M-1:0]  HSEL;
  logic [PB-1:0] prio  [M];
  logic [1:0]    trans [M];
  logic [M-1:0]  lock;
  logic          HREADY;
  logic          grant_valid;
  logic [M-1:0]  grant_onehot;
  logic [MB-1:0] grant_idx;
  logic          data_valid;
  logic [MB-1:0] data_idx;

  initial forever #5 HCLK = ~HCLK;

  ahb3lite_interconnect_slave_arbiter #(.MASTERS(M)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HSEL         (HSEL),
    .priority_i   (prio),
    .HTRANS       (trans),
    .HMASTLOCK    (lock),
    .HREADY       (HREADY),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .data_valid   (data_valid),
    .data_idx     (data_idx)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Abstract state: who owns the bus, who was granted last, who owns data.
  bit m_gv;
  int m_gi;
  int m_last;
  bit m_dv;
  int m_di;

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int  top;
    int  win;
    int  idx;
    bit  keep;
    if (HRESET) begin
      m_gv = 0; m_gi = 0; m_last = M - 1; m_dv = 0; m_di = 0;
    end else if (HREADY) begin
      keep = m_gv && HSEL[m_gi] &&
             (lock[m_gi] || trans[m_gi] == T_BUSY || trans[m_gi] == T_SEQ);
      m_dv = m_gv && HSEL[m_gi] && (trans[m_gi] == T_NONSEQ || trans[m_gi] == T_SEQ);
      m_di = m_gi;
      if (!keep) begin
        top = -1;
        for (int i = 0; i < M; i++)
          if (HSEL[i] && int'(prio[i]) > top) top = int'(prio[i]);
        win = -1;
        for (int k = 1; k <= M; k++) begin
          idx = (m_last + k) % M;
          if (win < 0 && HSEL[idx] && int'(prio[idx]) == top) win = idx;
        end
        if (win >= 0) begin
          m_gv = 1; m_gi = win; m_last = win;
        end else begin
          m_gv = 0;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("grant_valid",  32'(grant_valid),  32'(m_gv));
    chk("grant_idx",    32'(grant_idx),    32'(m_gi));
    chk("grant_onehot", 32'(grant_onehot), m_gv ? (32'd1 << m_gi) : 32'd0);
    chk("data_valid",   32'(data_valid),   32'(m_dv));
    chk("data_idx",     32'(data_idx),     32'(m_di));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    model_step();
    @(posedge HCLK);
    #1;
    check_model();
  endtask

  task automatic drive_idle();
    HSEL   = '0;
    lock   = '0;
    HREADY = 1'b1;
    for (int i = 0; i < M; i++) begin
      prio[i]  = '0;
      trans[i] = T_IDLE;
    end
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
  endtask

  task automatic drive_random();
    HSEL   = M'($urandom_range(0, 7));
    lock   = ($urandom_range(0, 3) == 0) ? M'($urandom_range(0, 7)) : '0;
    HREADY = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < M; i++) begin
      prio[i]  = PB'($urandom_range(0, 3));
      trans[i] = 2'($urandom_range(0, 3));
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int            rr_exp [5];
    logic          snap_gv;
    logic [MB-1:0] snap_gi;
    logic [M-1:0]  snap_oh;
    logic          snap_dv;
    logic [MB-1:0] snap_di;

    rr_exp = '{0, 1, 2, 0, 1};
    m_gv = 0; m_gi = 0; m_last = M - 1; m_dv = 0; m_di = 0;
    drive_idle();
    HRESET = 1'b1;

    // Reset state.
    tick();
    tick();
    HRESET = 1'b0;
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_onehot",      32'(grant_onehot), 32'd0);
    chk("rst_data_valid",  32'(data_valid),  32'd0);

    // Single request from master 1: grant next edge, data phase one later.
    HSEL = 3'b010;
    trans[1] = T_NONSEQ;
    tick();
    chk("single_grant_idx", 32'(grant_idx), 32'd1);
    chk("single_onehot",    32'(grant_onehot), 32'b010);
    tick();
    chk("single_data_valid", 32'(data_valid), 32'd1);
    chk("single_data_idx",   32'(data_idx),   32'd1);

    // Priority: master 2 highest, then master 1 once master 2 drops out.
    HSEL = 3'b111;
    prio[0] = 2'd0; prio[1] = 2'd1; prio[2] = 2'd2;
    for (int i = 0; i < M; i++) trans[i] = T_NONSEQ;
    tick();
    chk("prio_top", 32'(grant_idx), 32'd2);
    HSEL = 3'b011;
    tick();
    chk("prio_next", 32'(grant_idx), 32'd1);

    // Round-robin among equal priorities from a fresh pointer.
    do_reset();
    HSEL = 3'b111;
    for (int i = 0; i < M; i++) begin
      prio[i]  = '0;
      trans[i] = T_NONSEQ;
    end
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("rr_seq", 32'(grant_idx), 32'(rr_exp[r]));
    end

    // Burst hold: master 0 keeps the bus against a higher-priority master 1.
    do_reset();
    drive_idle();
    HSEL = 3'b001;
    trans[0] = T_NONSEQ;
    tick();
    chk("burst_start", 32'(grant_idx), 32'd0);
    HSEL = 3'b011;
    prio[1] = 2'd1;
    trans[1] = T_NONSEQ;
    foreach (rr_exp[r]) begin
      if (r == 4) break;
      trans[0] = (r == 2) ? T_BUSY : T_SEQ;
      tick();
      chk("burst_hold", 32'(grant_idx), 32'd0);
    end
    trans[0] = T_IDLE;
    tick();
    chk("burst_release", 32'(grant_idx), 32'd1);

    // Wait states: three HREADY=0 cycles freeze every output.
    tick();
    snap_gv = grant_valid; snap_gi = grant_idx; snap_oh = grant_onehot;
    snap_dv = data_valid;  snap_di = data_idx;
    for (int w = 0; w < 3; w++) begin
      drive_random();
      HREADY = 1'b0;
      tick();
      chk("wait_gv", 32'(grant_valid),  32'(snap_gv));
      chk("wait_gi", 32'(grant_idx),    32'(snap_gi));
      chk("wait_oh", 32'(grant_onehot), 32'(snap_oh));
      chk("wait_dv", 32'(data_valid),   32'(snap_dv));
      chk("wait_di", 32'(data_idx),     32'(snap_di));
    end

    // Lock: master 2 keeps the grant through IDLE while locked.
    drive_idle();
    do_reset();
    HSEL = 3'b100;
    lock = 3'b100;
    trans[2] = T_NONSEQ;
    tick();
    chk("lock_grant", 32'(grant_idx), 32'd2);
    trans[2] = T_IDLE;
    HSEL = 3'b111;
    prio[0] = 2'd2; prio[1] = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lock_hold", 32'(grant_idx), 32'd2);
    end
    lock = '0;
    tick();
    chk("lock_release", 32'(grant_idx), 32'd0);

    // Reset in the middle of a burst with wait states.
    trans[0] = T_SEQ;
    tick();
    HREADY = 1'b0;
    HRESET = 1'b1;
    tick();
    chk("midrst_gv", 32'(grant_valid),  32'd0);
    chk("midrst_oh", 32'(grant_onehot), 32'd0);
    chk("midrst_gi", 32'(grant_idx),    32'd0);
    chk("midrst_dv", 32'(data_valid),   32'd0);
    chk("midrst_di", 32'(data_idx),     32'd0);
    HRESET = 1'b0;
    HREADY = 1'b1;

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      drive_random();
      HRESET = ($urandom_range(0, 59) == 0);
      tick();
    end
    HRESET = 1'b0;

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ahb3lite_interconnect_slave_arbiter
